// File: rtl/mips_timer_if.sv
// +--------------------------------------------------------------------+
// | mips_timer_if : CPU data-bus port of the memory-mapped timer       |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

interface mips_timer_if;
  logic [31:0] addr;
  logic        WE;
  logic [31:0] WD;
  logic        sel;
  logic [31:0] RD;

  modport master (output addr, output WE, output WD, input sel, input RD);
  modport slave  (input addr, input WE, input WD, output sel, output RD);
endinterface

`default_nettype wire

// File: rtl/mips_timer.sv
// +--------------------------------------------------------------------+
// | mips_timer : memory-mapped countdown timer (CTRL/PRESET/COUNT)     |
// |              with one-shot / auto-reload modes and level IRQ.      |
// | Option     : define TIMER_PRESCALE_EN for the CTRL[15:8] prescaler |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none

module mips_timer #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_7F00,
  parameter int unsigned CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  mips_timer_if.slave bus,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_AUTO = 2'b01;

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic             im_q, im_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_flag_q, irq_flag_d;

  logic [29:0] off;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        step;
  logic [7:0]  ps_rd;
  logic [31:0] rd;
  logic        unused_ok;

  // Word offset relative to the base; the window is words 0..2 only.
  assign off       = bus.addr[31:2] - ADDR_BASE[31:2];
  assign bus.sel   = (off < 30'd3);
  assign wr_ctrl   = bus.WE & bus.sel & (off[1:0] == 2'd0);
  assign wr_preset = bus.WE & bus.sel & (off[1:0] == 2'd1);
  assign unused_ok = &{1'b0, bus.addr[1:0], bus.WD};

`ifdef TIMER_PRESCALE_EN
  logic [7:0] ps_q, ps_d;
  logic [7:0] pscnt_q, pscnt_d;

  assign step  = (pscnt_q == ps_q);
  assign ps_rd = ps_q;

  always_comb begin
    ps_d    = ps_q;
    pscnt_d = pscnt_q;
    if (state_q == S_CNT && en_q) begin
      pscnt_d = step ? 8'd0 : pscnt_q + 8'd1;
    end
    if (state_q == S_LOAD || wr_ctrl) begin
      pscnt_d = 8'd0;
    end
    if (wr_ctrl) begin
      ps_d = bus.WD[15:8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q    <= 8'd0;
      pscnt_q <= 8'd0;
    end else begin
      ps_q    <= ps_d;
      pscnt_q <= pscnt_d;
    end
  end
`else
  assign step  = 1'b1;
  assign ps_rd = 8'h00;
`endif

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    im_d       = im_q;
    mode_d     = mode_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    // Auto-reload flag is a one-cycle pulse; INT below re-asserts it.
    if (mode_q == MODE_AUTO) begin
      irq_flag_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // Look at the EN value being written so LOAD starts on the write edge.
        if (wr_ctrl ? bus.WD[0] : en_q) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (step) begin
          if (count_q <= CNT_W'(1)) begin
            count_d = '0;
            state_d = S_INT;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      S_INT: begin
        irq_flag_d = 1'b1;
        if (mode_q == MODE_AUTO) begin
          state_d = S_LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CPU writes override the FSM, including the one-shot EN clear.
    if (wr_ctrl) begin
      en_d       = bus.WD[0];
      mode_d     = bus.WD[2:1];
      im_d       = bus.WD[3];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d   = bus.WD[CNT_W-1:0];
      irq_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      im_q       <= 1'b0;
      mode_q     <= 2'b00;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      im_q       <= im_d;
      mode_q     <= mode_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    rd = 32'h0;
    if (bus.sel) begin
      case (off[1:0])
        2'd0: begin
          rd[3:0]  = {im_q, mode_q, en_q};
          rd[15:8] = ps_rd;
        end
        2'd1:    rd[CNT_W-1:0] = preset_q;
        2'd2:    rd[CNT_W-1:0] = count_q;
        default: rd = 32'h0;
      endcase
    end
  end

  assign bus.RD = rd;
  assign IRQ    = im_q & irq_flag_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_timer.sv
// +--------------------------------------------------------------------+
// | tb_mips_timer : directed self-checking bench for mips_timer        |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mips_timer;

  localparam logic [31:0] A_CTRL = 32'h0000_7F00;
  localparam logic [31:0] A_PRE  = 32'h0000_7F04;
  localparam logic [31:0] A_CNT  = 32'h0000_7F08;
  localparam logic [31:0] A_UNM  = 32'h0000_7F0C;
  localparam logic [31:0] A_LOW  = 32'h0000_7EFC;

  logic clk;
  logic rst;
  logic irq;
  int   n_chk  = 0;
  int   n_pass = 0;

  mips_timer_if bus ();

  mips_timer #(
    .ADDR_BASE (32'h0000_7F00),
    .CNT_W     (32)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus),
    .IRQ   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.WD   = d;
    bus.WE   = 1'b1;
    tick();
    bus.WE   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.RD, exp);
  endtask

  initial begin
    rst      = 1'b1;
    bus.addr = 32'h0;
    bus.WE   = 1'b0;
    bus.WD   = 32'h0;
    repeat (2) tick();

    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_pre", A_PRE, 32'h0);
    rd_chk("rst_cnt", A_CNT, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    tick();

    // One-shot: INT entered 6 edges after the enable write, IRQ 7 edges after.
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd_chk("os_count", A_CNT, 32'(6 - k));
      check("os_irq_low", {31'h0, irq}, 32'h0);
    end
    tick();
    check("os_irq_rise", {31'h0, irq}, 32'h1);
    rd_chk("os_ctrl", A_CTRL, 32'h8);
    repeat (3) tick();
    check("os_irq_hold", {31'h0, irq}, 32'h1);
    wr(A_CTRL, 32'h8);
    check("os_irq_clr", {31'h0, irq}, 32'h0);

    // PRESET=0 counts like PRESET=1.
    wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'h9);
    repeat (2) tick();
    check("p0_irq_low", {31'h0, irq}, 32'h0);
    tick();
    check("p0_irq_rise", {31'h0, irq}, 32'h1);
    wr(A_CTRL, 32'h0);
    check("p0_irq_clr", {31'h0, irq}, 32'h0);

    // Auto-reload: one-cycle pulse every 5 edges.
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int j = 1; j <= 20; j++) begin
      tick();
      check("ar_irq", {31'h0, irq}, (j % 5 == 0) ? 32'h1 : 32'h0);
      if (j % 5 == 1) rd_chk("ar_reload", A_CNT, 32'd3);
    end
    wr(A_CTRL, 32'h0);
    repeat (3) tick();

    // Masked interrupt: EN still self-clears, IRQ stays low.
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("mask_irq", {31'h0, irq}, 32'h0);
    end
    rd_chk("mask_ctrl", A_CTRL, 32'h0);
    rd_chk("mask_cnt", A_CNT, 32'h0);

    // Address decode.
    bus.addr = A_UNM;
    #1;
    check("unm_sel", {31'h0, bus.sel}, 32'h0);
    check("unm_rd", bus.RD, 32'h0);
    bus.addr = A_LOW;
    #1;
    check("low_sel", {31'h0, bus.sel}, 32'h0);
    bus.addr = A_CNT;
    #1;
    check("cnt_sel", {31'h0, bus.sel}, 32'h1);

    // Stop mid-count, read-only COUNT, reload, PRESET write during CNT.
    wr(A_PRE, 32'd100);
    wr(A_CTRL, 32'h1);
    repeat (51) tick();
    rd_chk("stop_at50", A_CNT, 32'd50);
    wr(A_CTRL, 32'h0);
    rd_chk("stop_dec", A_CNT, 32'd49);
    repeat (3) tick();
    rd_chk("stop_frozen", A_CNT, 32'd49);
    wr(A_CNT, 32'hFFFF);
    rd_chk("cnt_ro", A_CNT, 32'd49);
    wr(A_CTRL, 32'h1);
    tick();
    rd_chk("reload", A_CNT, 32'd100);
    wr(A_PRE, 32'd7);
    rd_chk("pre_wr_cnt", A_CNT, 32'd99);
    tick();
    rd_chk("pre_wr_cnt2", A_CNT, 32'd98);
    rd_chk("pre_rd", A_PRE, 32'd7);
    wr(A_CTRL, 32'h0);
    repeat (2) tick();

    // CTRL[15:8] has no storage without the prescaler option.
    wr(A_CTRL, 32'h0000_FF08);
    rd_chk("ps_ignored", A_CTRL, 32'h8);
    wr(A_CTRL, 32'h0);

    // Asynchronous reset in the middle of a count.
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h1);
    repeat (4) tick();
    rd_chk("mid_cnt", A_CNT, 32'd7);
    rst = 1'b1;
    #1;
    rd_chk("arst_ctrl", A_CTRL, 32'h0);
    rd_chk("arst_pre", A_PRE, 32'h0);
    rd_chk("arst_cnt", A_CNT, 32'h0);
    check("arst_irq", {31'h0, irq}, 32'h0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    rd_chk("post_rst_cnt", A_CNT, 32'h0);
    rd_chk("post_rst_ctrl", A_CTRL, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_timer.md
Name: mips_timer

Overview:
- Memory-mapped countdown timer. It is the responder on the CPU data-bus: the processor datapath issues load/store addresses and write data, and this block decodes, services and answers them.
- Sits beside the data memory behind the address decode. Provides a programmable interval counter and a level interrupt request to the processor.
- Register file is three words: CTRL, PRESET and COUNT.

Parameters:
- ADDR_BASE, 32'h0000_7F00, word-aligned base of the 3-word register window.
- CNT_W, 32, width of PRESET/COUNT (≤32); upper read bits zero-filled.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  byte address from ALU result; bits [1:0] ignored.
- WE  input  1  write strobe, qualified by address hit.
- WD  input  32  write data (store data from rt).
- sel  output  1  combinational: addr falls in [ADDR_BASE, ADDR_BASE+8].
- RD  output  32  combinational read data for the addressed register; 0 when sel=0.
- IRQ  output  1  interrupt request = CTRL.IM & irq_flag.

Behaviour:
- Register map, offset = addr[3:2]:
  - 0 = CTRL, R/W. Bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM. Other bits read 0.
  - 1 = PRESET, R/W.
  - 2 = COUNT, read-only; writes ignored.
  - 3 = unmapped: sel=0, RD=0.
- Writes take effect at the rising clk when WE & sel. Reads are same-cycle combinational, so a single-cycle CPU loads in the same cycle.
- Reset (async, asserted): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, RD=0 when unaddressed, IRQ=0. Reset mid-count aborts immediately; there is no pending state.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if CTRL.EN=1 → LOAD.
  - LOAD: COUNT←PRESET; → CNT.
  - CNT: if EN=0 → IDLE, COUNT frozen. Else if COUNT==1 or COUNT==0 → INT with COUNT←0. Else COUNT←COUNT−1.
  - INT, MODE 00: irq_flag←1, CTRL.EN←0, → IDLE. irq_flag holds until cleared.
  - INT, MODE 01: irq_flag←1 for this single cycle only (cleared on the next edge), → LOAD. Reload is automatic.
- Interval: with EN set at edge t0, from IDLE, PRESET=N≥1, INT is entered at edge t0+N+1. IRQ is visible from t0+N+2 (IRQ is registered through irq_flag).
- PRESET=0 behaves as PRESET=1.
- irq_flag clears on any CPU write to CTRL or PRESET, on reset, or after one cycle in MODE 01.
- Simultaneous CPU write and FSM update:
  - CPU write to CTRL wins over the FSM's EN clear in INT.
  - A write clearing EN during CNT → IDLE next cycle.
  - A PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
- Wrap-around: COUNT never underflows; it saturates at 0.
- IM=0 masks IRQ only; irq_flag still sets and is cleared as above.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- With it defined: CTRL[15:8] is PS, R/W, reset 0. An 8-bit prescale counter gates decrement, so CNT decrements once every PS+1 cycles. The prescale counter resets to 0 on LOAD and on any CTRL write. Interval becomes (PS+1)·N+1 edges to INT.
- Without it: CTRL[15:8] reads 0 and writes are ignored; decrement occurs every CNT cycle.

Test Plan:
- Reset mid-count: set PRESET=10, CTRL=1, assert reset at cycle 5 → all registers read 0, IRQ=0 the same cycle, state IDLE after release.
- One-shot: PRESET=5, CTRL=0x9 (EN, IM, mode 00) → COUNT reads 5,4,3,2,1,0. IRQ rises 7 cycles after the CTRL write edge and stays 1; CTRL reads 0x8. Writing CTRL=0x8 drops IRQ next cycle.
- Auto-reload: PRESET=3, CTRL=0xB → IRQ single-cycle pulses every 5 cycles (LOAD + 3 CNT + INT), repeating 4 times; COUNT returns to 3 after each pulse.
- Masking and readback: CTRL=0x1, PRESET=2 → irq_flag sets, IRQ stays 0. Write to COUNT (addr base+8, WD=0xFFFF) → COUNT unchanged. Read of base+0xC → sel=0, RD=0.
- Stop/priority: mode 00 with PRESET=100; at COUNT=50 write CTRL=0 → COUNT frozen at 49 or 50 per edge, state IDLE. Writing CTRL=1 reloads to 100. A PRESET write during CNT leaves COUNT decrementing unchanged.
- Prescale (macro on): PS=3, PRESET=2 → INT reached at edge (4·2)+1=9 after the enable write.
